// File: rtl/mem_resp_pipe.sv
// Tagged main-memory responder: one line load/store per cycle, non-zero tag
// returned in the request cycle, load data delivered LATENCY cycles later.
module mem_resp_pipe #(
  parameter int unsigned MEM_LINES = 8192,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int unsigned IDX_W  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned LINE_W = XLEN - 3;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 64;

  localparam logic [1:0]       BUS_LOAD  = 2'd1;
  localparam logic [1:0]       BUS_STORE = 2'd2;
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(15);

  logic [DATA_W-1:0] unified_memory [MEM_LINES];

  logic [TAG_W-1:0]                 next_tag_q, next_tag_d;
  logic [LATENCY-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [LATENCY-1:0][DATA_W-1:0]   data_q, data_d;

  logic [LINE_W-1:0] line_c;
  logic [IDX_W-1:0]  idx_c;
  logic              in_range_c;
  logic              is_load_c;
  logic              is_store_c;
  logic              accept_c;
  logic              unused_addr_lsbs;

  // Request decode; command 3 and out-of-range lines are silently rejected.
  assign line_c           = proc2mem_addr[XLEN-1:3];
  assign idx_c            = proc2mem_addr[IDX_W+2:3];
  assign unused_addr_lsbs = ^proc2mem_addr[2:0];
  assign in_range_c       = (64'(line_c) < 64'(MEM_LINES));
  assign is_load_c        = (proc2mem_command == BUS_LOAD);
  assign is_store_c       = (proc2mem_command == BUS_STORE);
  assign accept_c         = reset && in_range_c && (is_load_c || is_store_c);

  assign mem2proc_response = accept_c ? next_tag_q : '0;
  assign mem2proc_tag      = tag_q[LATENCY-1];
  assign mem2proc_data     = data_q[LATENCY-1];

  // Tag allocator and completion pipeline next-state.
  always_comb begin
    next_tag_d = next_tag_q;
    tag_d      = '0;
    data_d     = '0;

    if (accept_c) begin
      next_tag_d = (next_tag_q == TAG_LAST) ? TAG_FIRST : next_tag_q + TAG_W'(1);
    end

    if (accept_c && is_load_c) begin
      tag_d[0]  = next_tag_q;
      data_d[0] = unified_memory[idx_c];
    end

    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_d[i]  = tag_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next_tag_q <= TAG_FIRST;
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      next_tag_q <= next_tag_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  // Memory contents survive reset; the write is gated by acceptance, which includes reset.
  always_ff @(posedge clock) begin
    if (accept_c && is_store_c) begin
      unified_memory[idx_c] <= proc2mem_data;
    end
  end

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Bench for mem_resp_pipe: directed scenarios plus random traffic, compared
// against a cycle-indexed completion schedule and a sparse memory model.
module tb_mem_resp_pipe;

  localparam int unsigned MEM_LINES = 8192;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned XLEN      = 32;

  logic            clock;
  logic            reset;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  mem_resp_pipe #(
    .MEM_LINES(MEM_LINES),
    .LATENCY  (LATENCY),
    .XLEN     (XLEN)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2mem_command (proc2mem_command),
    .proc2mem_addr    (proc2mem_addr),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_accepted = 0;

  // Reference state: line contents as written over the bus, and the completion
  // expected in each future cycle.
  logic [63:0] mem_model [int unsigned];
  logic [3:0]  exp_tag   [int];
  logic [63:0] exp_data  [int];
  logic        exp_known [int];

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  // One bus cycle: drive, check response and outputs mid-cycle, update the model.
  task automatic step(input logic rst_v, input logic [1:0] cmd,
                      input logic [31:0] addr, input logic [63:0] wdata);
    int unsigned line;
    logic        acc;
    logic [3:0]  exp_rsp;
    reset            = rst_v;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = wdata;
    if (!rst_v) begin
      exp_tag.delete();
      exp_data.delete();
      exp_known.delete();
      n_accepted = 0;
    end
    line    = addr >> 3;
    acc     = rst_v && (cmd == 2'd1 || cmd == 2'd2) && (line < MEM_LINES);
    exp_rsp = acc ? 4'((n_accepted % 15) + 1) : 4'd0;

    @(negedge clock);
    check_val("response", 64'(mem2proc_response), 64'(exp_rsp));
    if (exp_tag.exists(cyc)) begin
      check_val("cpl_tag", 64'(mem2proc_tag), 64'(exp_tag[cyc]));
      if (exp_known[cyc]) check_val("cpl_data", mem2proc_data, exp_data[cyc]);
      exp_tag.delete(cyc);
      exp_data.delete(cyc);
      exp_known.delete(cyc);
    end else begin
      check_val("idle_tag", 64'(mem2proc_tag), 64'd0);
      check_val("idle_data", mem2proc_data, 64'd0);
    end

    if (acc) begin
      if (cmd == 2'd1) begin
        exp_tag[cyc + int'(LATENCY)]   = exp_rsp;
        exp_known[cyc + int'(LATENCY)] = mem_model.exists(line);
        exp_data[cyc + int'(LATENCY)]  = mem_model.exists(line) ? mem_model[line] : 64'd0;
      end else begin
        mem_model[line] = wdata;
      end
      n_accepted++;
    end

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'd0, 32'd0, 64'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  cmd;
    int unsigned line;

    reset            = 1'b0;
    proc2mem_command = 2'd1;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    @(posedge clock);
    #1;

    // Held in reset with a LOAD presented: everything reads zero.
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 32'h0, 64'd0);

    // First request after release gets tag 1 (line 0 contents not yet known).
    step(1'b1, 2'd1, 32'h0, 64'd0);
    idle(LATENCY + 1);

    // Populate lines 0..63 over the bus; line 2 gets a recognisable pattern.
    for (int i = 0; i < 64; i++)
      step(1'b1, 2'd2, 32'(i * 8), (i == 2) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom});
    idle(2);

    // Single load of line 2.
    step(1'b1, 2'd1, 32'h10, 64'd0);
    idle(LATENCY + 2);

    // Back-to-back loads of lines 0, 1, 2.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'(i * 8), 64'd0);
    idle(LATENCY + 2);

    // Store/load ordering on one line in consecutive cycles.
    step(1'b1, 2'd2, 32'h20, 64'h1111);
    step(1'b1, 2'd1, 32'h20, 64'd0);
    step(1'b1, 2'd2, 32'h20, 64'h2222);
    step(1'b1, 2'd1, 32'h20, 64'd0);
    idle(LATENCY + 2);

    // Rejections: out-of-range load/store and command 3, interleaved with loads.
    step(1'b1, 2'd1, 32'(MEM_LINES * 8), 64'd0);
    step(1'b1, 2'd2, 32'(MEM_LINES * 8 + 8), 64'hBAD);
    step(1'b1, 2'd3, 32'h18, 64'd0);
    step(1'b1, 2'd1, 32'h18, 64'd0);
    idle(LATENCY + 2);

    // Reset then an exact tag wrap: 16 accepted commands on fresh tags.
    step(1'b0, 2'd0, 32'd0, 64'd0);
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2 == 0) ? 2'd2 : 2'd1, 32'h28, 64'(i));
    idle(LATENCY + 2);

    // Random traffic, including rejected commands and out-of-range lines.
    for (int i = 0; i < 400; i++) begin
      cmd  = 2'($urandom_range(0, 3));
      line = ($urandom_range(0, 15) == 0) ? MEM_LINES + $urandom_range(0, 100)
                                           : $urandom_range(0, 63);
      addr = {29'(line), 3'($urandom_range(0, 7))};
      step(1'b1, cmd, addr, {$urandom, $urandom});
    end
    idle(LATENCY + 2);

    // Reset mid-flight: the in-flight load never completes; memory survives.
    step(1'b1, 2'd2, 32'h30, 64'hCAFE_F00D_0000_0006);
    step(1'b1, 2'd1, 32'h8, 64'd0);
    step(1'b1, 2'd0, 32'd0, 64'd0);
    step(1'b0, 2'd1, 32'h8, 64'd0);
    step(1'b1, 2'd1, 32'h30, 64'd0);
    idle(LATENCY + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_resp_pipe.md
# mem_resp_pipe

Synthesizable tagged main-memory responder that sits directly downstream of `processor` on the `proc2mem_*` / `mem2proc_*` bus, in the position the behavioural `mem` model occupies in simulation. It accepts one 64-bit line load or store per cycle and returns a non-zero transaction tag in the request cycle. Each load's data is delivered with its tag a fixed number of cycles later. The block lets the core run against a cycle-exact, reset-aware memory in both the testbench and synthesis (CACHE_MODE bus, no `proc2mem_size`).

## Interface
- `MEM_LINES`, 8192: number of 64-bit lines in `unified_memory` (byte capacity = `MEM_LINES*8`).
- `LATENCY`, 4: cycles from request to load completion; legal range 1..15.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (asserted when 0).
- `proc2mem_command`  in  2  0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE, 3 = treated as BUS_NONE.
- `proc2mem_addr`  in  `XLEN`  byte address; bits [2:0] ignored; line index = addr[31:3].
- `proc2mem_data`  in  64  store data.
- `mem2proc_response`  out  4  tag of the accepted request, combinational in the request cycle; 0 = not accepted.
- `mem2proc_data`  out  64  load data; registered; valid only while `mem2proc_tag` != 0.
- `mem2proc_tag`  out  4  completing load's tag; registered; 0 = no completion this cycle.
- `unified_memory[MEM_LINES]` internal array, 64 bits per line. Benches may backdoor it with `$readmemh` and read it for memory dumps. It is not cleared by reset.

## Operation
- Acceptance:
  - A request is accepted when `reset` = 1, the command is LOAD or STORE, and addr[31:3] < `MEM_LINES`.
  - Otherwise the response is 0 and nothing changes: no write, no tag advance, no completion.
- Tag allocator:
  - `next_tag` register, reset value 1.
  - `mem2proc_response` = `next_tag` on acceptance.
  - `next_tag` advances on every accepted load or store; it wraps from 15 to 1 and never produces 0.
- Store: the line is written at the accepting posedge. A store returns a tag but never produces a completion.
- Load:
  - The line is read at the accepting posedge; this is a snapshot, so later stores do not alter in-flight data.
  - `{tag, data}` enter a `LATENCY`-deep shift pipeline.
  - A pipeline slot with no accepted load carries tag 0.
  - The pipeline head drives `mem2proc_tag` / `mem2proc_data`. Data is 0 whenever the tag is 0.
- Ordering and uniqueness: completions return in acceptance order. Because `LATENCY` ≤ 15 and at most one request is accepted per cycle, outstanding tags are always unique.
- Load after store: a load accepted after a store to the same line, even in the next cycle, returns the stored data.

## Timing
- While `reset` = 0 (asynchronous):
  - `mem2proc_response` = 0.
  - `mem2proc_tag` = 0 and `mem2proc_data` = 0 immediately.
  - The pipeline is flushed to tag 0 and `next_tag` = 1.
- Reset mid-operation: every in-flight load is discarded and never completes. Stores already accepted remain in memory.
- Load latency: a load is accepted in cycle N, with its response visible combinationally in N. `mem2proc_tag` = that tag and `mem2proc_data` = the line during cycle N+`LATENCY` only, for exactly one cycle.
- Throughput: one accepted request per cycle, sustained indefinitely; there is no stall condition.
- Simultaneous events:
  - A completion and a new acceptance in the same cycle are independent.
  - A store accepted in the same cycle as a completion of the same line does not change the completing data.
- `mem2proc_response` depends combinationally only on command, address, `reset`, and `next_tag`. It must not depend on `mem2proc_tag`.

## Test plan
- Reset: hold `reset` = 0 with command = LOAD → response = 0, tag = 0, data = 0. Release, then LOAD addr 0x0 → response = 1.
- Single load, `LATENCY` = 4, `unified_memory[2]` = 64'hDEAD_BEEF_0123_4567: LOAD 0x10 in cycle N → response 1 in N; tag = 1 and data match in N+4; tag = 0 in N+3 and N+5.
- Back-to-back: LOADs to lines 0, 1, 2 in N, N+1, N+2 → responses 1, 2, 3. Completions carry tags 1, 2, 3 with matching data in N+4, N+5, N+6.
- Store/load ordering, in four consecutive cycles:
  - STORE 0x20 with data 64'h1111;
  - LOAD 0x20 → completes with 64'h1111;
  - STORE 0x20 with data 64'h2222;
  - LOAD 0x20 → completes with 64'h2222.
- Tag wrap and rejection:
  - 15 accepted commands → responses 1..15; the 16th returns 1.
  - LOAD at addr `MEM_LINES*8` → response 0, `next_tag` unchanged, no completion.
  - command = 3 → response 0.
- Reset mid-flight: LOAD 0x8 in cycle N, then assert `reset` in N+2 for 1 cycle → no tag-1 completion ever appears. The first post-reset request gets tag 1, and stores made before the reset remain in memory.
